// File: rtl/country_vehicle_detector.sv
// country_vehicle_detector
// Conditions a raw inductive-loop sensor into debounced vehicle arrivals.
// Keeps a saturating count of waiting vehicles and discharges it while the
// country signal is GREEN. Raises vehicle_req while any vehicle is waiting.
module country_vehicle_detector #(
  parameter int DEBOUNCE      = 3,
  parameter int DEPART_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             loop_raw,
  input  logic [1:0]       country_sig,
  output logic             vehicle_req,
  output logic [CNT_W-1:0] queue_count,
  output logic             arrival,
  output logic             overflow,
  output logic             sig_error
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int DEP_W = $clog2(DEPART_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEP_W-1:0] DEP_LAST = DEP_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE_LOW,
    RISE_CHK,
    IDLE_HIGH,
    FALL_CHK
  } deb_state_e;

  logic             meta_q, sync_q;
  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEP_W-1:0] dep_timer_q, dep_timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             arrival_q, arrival_d;
  logic             req_q, overflow_q, overflow_d, sig_error_q, sig_error_d;
  logic             depart;

  // Two-flop synchroniser for the asynchronous loop sensor.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= loop_raw;
      sync_q <= meta_q;
    end
  end

  // Debounce FSM: accept a level only after DEBOUNCE agreeing samples.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    arrival_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          state_d   = RISE_CHK;
          deb_cnt_d = DEB_W'(1);
        end
      end
      RISE_CHK: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE_HIGH;
          arrival_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          state_d   = FALL_CHK;
          deb_cnt_d = DEB_W'(1);
        end
      end
      FALL_CHK: begin
        if (sync_q) begin
          state_d = IDLE_HIGH;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  // Departure timer and queue counter next-state; illegal signal counts as not GREEN.
  always_comb begin
    dep_timer_d = '0;
    depart      = 1'b0;
    count_d     = count_q;
    overflow_d  = overflow_q;
    sig_error_d = sig_error_q | (country_sig == 2'd3);
    if ((country_sig == 2'd2) && (count_q != '0)) begin
      if (dep_timer_q == DEP_LAST) begin
        depart = 1'b1;
      end else begin
        dep_timer_d = dep_timer_q + DEP_W'(1);
      end
    end
    case ({arrival_d, depart})
      2'b10: begin
        if (count_q == CNT_MAX) overflow_d = 1'b1;
        else                    count_d    = count_q + CNT_W'(1);
      end
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and output registers; reset discards any in-progress debounce or departure.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE_LOW;
      deb_cnt_q   <= '0;
      dep_timer_q <= '0;
      count_q     <= '0;
      arrival_q   <= 1'b0;
      req_q       <= 1'b0;
      overflow_q  <= 1'b0;
      sig_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      dep_timer_q <= dep_timer_d;
      count_q     <= count_d;
      arrival_q   <= arrival_d;
      req_q       <= (count_d != '0);
      overflow_q  <= overflow_d;
      sig_error_q <= sig_error_d;
    end
  end

  assign vehicle_req = req_q;
  assign queue_count = count_q;
  assign arrival     = arrival_q;
  assign overflow    = overflow_q;
  assign sig_error   = sig_error_q;

endmodule

// File: tb/tb_country_vehicle_detector.sv
// Self-checking bench for country_vehicle_detector: directed scenarios plus
// randomized sensor/signal traffic against a run-length behavioural model.
module tb_country_vehicle_detector;

  localparam int D   = 3;
  localparam int DEP = 4;
  localparam int W   = 2;
  localparam int MAX = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         loop_raw = 1'b0;
  logic [1:0]   country_sig = 2'd0;
  logic         vehicle_req;
  logic [W-1:0] queue_count;
  logic         arrival;
  logic         overflow;
  logic         sig_error;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   m_d1, m_d2;          // loop value seen one/two edges ago
  int   m_run_val, m_run_len; // current run of identical synchronised samples
  int   m_level;              // accepted (debounced) level
  int   m_green;              // consecutive qualifying GREEN edges
  int   m_cnt;
  bit   m_arr, m_ovf, m_serr;

  country_vehicle_detector #(.DEBOUNCE(D), .DEPART_CYCLES(DEP), .CNT_W(W)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .loop_raw    (loop_raw),
    .country_sig (country_sig),
    .vehicle_req (vehicle_req),
    .queue_count (queue_count),
    .arrival     (arrival),
    .overflow    (overflow),
    .sig_error   (sig_error)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_run_val = 0; m_run_len = 0; m_level = 0;
    m_green = 0; m_cnt = 0; m_arr = 0; m_ovf = 0; m_serr = 0;
  endtask

  // One clock edge of the model: a level is accepted once a run of D equal
  // samples disagrees with the current level; a vehicle leaves every DEP
  // consecutive GREEN edges while someone is waiting.
  task automatic model_edge(input int l, input int c);
    int  s;
    bit  dep;
    s = m_d2; m_d2 = m_d1; m_d1 = l;
    if (s == m_run_val) m_run_len++;
    else begin m_run_val = s; m_run_len = 1; end
    m_arr = 0;
    if (m_run_val != m_level && m_run_len >= D) begin
      m_level = m_run_val;
      m_arr   = (m_level == 1);
    end
    dep = 0;
    if (c == 2 && m_cnt != 0) begin
      m_green++;
      if (m_green == DEP) begin dep = 1; m_green = 0; end
    end else begin
      m_green = 0;
    end
    if (c == 3) m_serr = 1;
    if (m_arr && !dep) begin
      if (m_cnt == MAX) m_ovf = 1;
      else m_cnt++;
    end else if (dep && !m_arr) begin
      m_cnt--;
    end
  endtask

  // Drive one cycle, advance the model, and compare every output #1 after the edge.
  task automatic cycle(input logic l, input logic [1:0] c);
    logic [W+3:0] exp_v, got_v;
    logic [W-1:0] exp_q;
    loop_raw    = l;
    country_sig = c;
    @(posedge clock);
    model_edge(int'(l), int'(c));
    #1;
    exp_q = m_cnt[W-1:0];
    exp_v = {m_arr, exp_q, (m_cnt != 0), m_ovf, m_serr};
    got_v = {arrival, queue_count, vehicle_req, overflow, sig_error};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model @%0t: got {arr,q,req,ovf,serr}=%b required %b", $time, got_v, exp_v);
    end
  endtask

  task automatic apply_reset();
    #2 clear_n = 1'b0;
    loop_raw = 1'b0;
    country_sig = 2'd0;
    @(posedge clock);
    #1 clear_n = 1'b1;
    model_reset();
  endtask

  task automatic arrive_one(input logic [1:0] c);
    repeat (D + 1) cycle(1'b1, c);
    repeat (D + 3) cycle(1'b0, c);
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    #3;
    checks++;
    if ({arrival, queue_count, vehicle_req, overflow, sig_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {arrival, queue_count, vehicle_req, overflow, sig_error});
    end
    @(posedge clock);
    #1 clear_n = 1'b1;
    model_reset();
    repeat (3) cycle(1'b0, 2'd0);
  endtask

  task automatic test_short_pulse();
    int seen = 0;
    repeat (D - 1) cycle(1'b1, 2'd0);
    repeat (8) begin
      cycle(1'b0, 2'd0);
      if (arrival) seen++;
    end
    checks++;
    if (seen != 0 || queue_count !== '0) begin
      errors++;
      $display("FAIL short_pulse: got arrivals=%0d q=%0d required 0 and 0", seen, queue_count);
    end
  endtask

  task automatic test_arrival_latency();
    int first_edge = -1, pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle((i <= 10) ? 1'b1 : 1'b0, 2'd0);
      if (arrival) begin
        pulses++;
        if (first_edge < 0) first_edge = i;
      end
    end
    checks++;
    if (first_edge != D + 2) begin
      errors++;
      $display("FAIL arrival_latency: got edge %0d required %0d", first_edge, D + 2);
    end
    checks++;
    if (pulses != 1 || queue_count !== W'(1) || vehicle_req !== 1'b1) begin
      errors++;
      $display("FAIL arrival_once: got pulses=%0d q=%0d req=%b required 1,1,1", pulses, queue_count, vehicle_req);
    end
  endtask

  task automatic test_departure();
    logic [W-1:0] q_at [1:10];
    logic         r_at [1:10];
    arrive_one(2'd0);
    for (int j = 1; j <= 10; j++) begin
      cycle(1'b0, 2'd2);
      q_at[j] = queue_count;
      r_at[j] = vehicle_req;
    end
    checks++;
    if (q_at[3] !== W'(2) || q_at[4] !== W'(1) || q_at[7] !== W'(1) || q_at[8] !== W'(0)) begin
      errors++;
      $display("FAIL departure_timing: got q3=%0d q4=%0d q7=%0d q8=%0d required 2,1,1,0",
               q_at[3], q_at[4], q_at[7], q_at[8]);
    end
    checks++;
    if (r_at[7] !== 1'b1 || r_at[8] !== 1'b0) begin
      errors++;
      $display("FAIL departure_req: got req7=%b req8=%b required 1,0", r_at[7], r_at[8]);
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) arrive_one(2'd0);
    cycle(1'b1, 2'd0);
    repeat (3) cycle(1'b1, 2'd2);
    cycle(1'b1, 2'd2);
    checks++;
    if (arrival !== 1'b1 || queue_count !== W'(3) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL arrive_and_depart: got arr=%b q=%0d ovf=%b required 1,3,0", arrival, queue_count, overflow);
    end
    repeat (D + 3) cycle(1'b0, 2'd0);
  endtask

  task automatic test_overflow();
    apply_reset();
    repeat (3) arrive_one(2'd0);
    checks++;
    if (queue_count !== W'(3) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pre_overflow: got q=%0d ovf=%b required 3,0", queue_count, overflow);
    end
    arrive_one(2'd0);
    checks++;
    if (queue_count !== W'(3) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got q=%0d ovf=%b required 3,1", queue_count, overflow);
    end
    repeat (DEP) cycle(1'b0, 2'd2);
    repeat (2) cycle(1'b0, 2'd0);
    checks++;
    if (queue_count !== W'(2) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_depart: got q=%0d ovf=%b required 2,1", queue_count, overflow);
    end
  endtask

  task automatic test_sig_error();
    cycle(1'b0, 2'd3);
    repeat (3) cycle(1'b0, 2'd0);
    repeat (2 * DEP) cycle(1'b0, 2'd3);
    checks++;
    if (sig_error !== 1'b1 || queue_count !== W'(2)) begin
      errors++;
      $display("FAIL sig_error: got serr=%b q=%0d required 1,2", sig_error, queue_count);
    end
    // Reset in the middle of a debounce must clear everything at once.
    repeat (2) cycle(1'b1, 2'd0);
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({arrival, queue_count, vehicle_req, overflow, sig_error} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0", {arrival, queue_count, vehicle_req, overflow, sig_error});
    end
    loop_raw = 1'b0;
    @(posedge clock);
    #1 clear_n = 1'b1;
    model_reset();
    repeat (8) cycle(1'b0, 2'd0);
  endtask

  task automatic test_random();
    logic       l;
    logic [1:0] c;
    int         seg_l = 0, seg_c = 0;
    apply_reset();
    l = 1'b0;
    c = 2'd0;
    for (int i = 0; i < 800; i++) begin
      if (seg_l == 0) begin
        l     = 1'($urandom_range(0, 1));
        seg_l = $urandom_range(1, 7);
      end
      if (seg_c == 0) begin
        c     = ($urandom_range(0, 99) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
        seg_c = $urandom_range(1, 12);
      end
      cycle(l, c);
      seg_l--;
      seg_c--;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_pulse();
    test_arrival_latency();
    test_departure();
    test_back_to_back();
    test_overflow();
    test_sig_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
